// File: rtl/uart_frame_pkg.sv
// Shared constants and types for the UART frame receiver.
package uart_frame_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        HUNT    = 3'd0,
        LEN     = 3'd1,
        PAYLOAD = 3'd2,
        CHECK   = 3'd3,
        DRAIN   = 3'd4
    } state_t;

    localparam logic [1:0] ERR_LEN     = 2'd0;
    localparam logic [1:0] ERR_CSUM    = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: simple dual-port RAM, synchronous write, registered read.
module uart_frame_buf
    import uart_frame_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [BYTE_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [BYTE_W-1:0] rd_data
);

    logic [BYTE_W-1:0] mem [DEPTH];

    // Payload byte write
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read register holds the presented byte until the next read request
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/uart_frame_rx.sv
// UART frame receiver: hunts for sync, parses [SYNC][LEN][PAYLOAD][CSUM],
// releases verified payload as a valid/ready stream.
// Optional inter-byte timeout enabled by defining UART_FRAME_TIMEOUT_EN.
module uart_frame_rx
    import uart_frame_pkg::*;
#(
    parameter int unsigned MAX_LEN        = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       receivable,
    input  logic [7:0] recv_data,
    output logic       recv_flag,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       frame_err,
    output logic [1:0] err_code
);

    localparam int unsigned PW = $clog2(MAX_LEN) + 1;
    localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_t        state;
    logic [7:0]    len;
    logic [7:0]    csum;
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [PW-1:0] rptr_nxt;
    logic          hs;
    logic          load;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          to_hit;

    // Pop whenever a byte is waiting and the parser is not draining
    assign recv_flag = receivable && (state == HUNT || state == LEN ||
                                      state == PAYLOAD || state == CHECK);

    assign hs       = out_valid && out_ready;
    assign rptr_nxt = rptr + PW'(1);
    assign load     = recv_flag && (state == CHECK) && (recv_data == csum);
    assign rd_en    = load || (hs && !out_last);
    assign rd_addr  = load ? '0 : rptr_nxt[AW-1:0];

`ifdef UART_FRAME_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TW-1:0] to_cnt;
    logic          waiting;

    assign waiting = (state == LEN || state == PAYLOAD || state == CHECK) && !recv_flag;
    assign to_hit  = waiting && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Inter-byte idle counter; cleared on pops and outside the frame body
    always_ff @(posedge CLK) begin
        if (RST || !waiting) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + TW'(1);
        end
    end
`else
    assign to_hit = 1'b0;
`endif

    // Frame parser, checksum, pointers and registered stream/error outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= HUNT;
            len       <= '0;
            csum      <= '0;
            wptr      <= '0;
            rptr      <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= ERR_LEN;
        end else begin
            frame_err <= 1'b0;
            if (to_hit) begin
                frame_err <= 1'b1;
                err_code  <= ERR_TIMEOUT;
                state     <= HUNT;
            end else begin
                case (state)
                    HUNT: begin
                        if (recv_flag && recv_data == SYNC_BYTE) begin
                            state <= LEN;
                        end
                    end
                    LEN: begin
                        if (recv_flag) begin
                            if (recv_data == 8'd0 || recv_data > MAX_LEN_B) begin
                                frame_err <= 1'b1;
                                err_code  <= ERR_LEN;
                                state     <= HUNT;
                            end else begin
                                len   <= recv_data;
                                csum  <= recv_data;
                                wptr  <= '0;
                                state <= PAYLOAD;
                            end
                        end
                    end
                    PAYLOAD: begin
                        if (recv_flag) begin
                            csum <= csum ^ recv_data;
                            wptr <= wptr + PW'(1);
                            if (8'(wptr) + 8'd1 == len) begin
                                state <= CHECK;
                            end
                        end
                    end
                    CHECK: begin
                        if (recv_flag) begin
                            if (recv_data == csum) begin
                                state     <= DRAIN;
                                rptr      <= '0;
                                out_valid <= 1'b1;
                                out_last  <= (len == 8'd1);
                            end else begin
                                frame_err <= 1'b1;
                                err_code  <= ERR_CSUM;
                                state     <= HUNT;
                            end
                        end
                    end
                    DRAIN: begin
                        if (hs) begin
                            if (out_last) begin
                                state     <= HUNT;
                                out_valid <= 1'b0;
                                out_last  <= 1'b0;
                            end else begin
                                rptr     <= rptr_nxt;
                                out_last <= (8'(rptr_nxt) == len - 8'd1);
                            end
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

    uart_frame_buf #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buf (
        .CLK     (CLK),
        .RST     (RST),
        .wr_en   (recv_flag && state == PAYLOAD),
        .wr_addr (wptr[AW-1:0]),
        .wr_data (recv_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (out_data)
    );

endmodule

// File: tb/tb_uart_frame_rx.sv
// Self-checking bench for uart_frame_rx: FIFO model on the input side,
// scoreboard queues for payload bytes and frame errors on the output side.
module tb_uart_frame_rx;
    import uart_frame_pkg::*;

    localparam int unsigned MAX_LEN        = 16;
    localparam int unsigned TIMEOUT_CYCLES = 50;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       receivable = 1'b0;
    logic [7:0] recv_data = 8'h00;
    logic       recv_flag;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       out_last;
    logic       frame_err;
    logic [1:0] err_code;

    always #5 CLK = ~CLK;

    uart_frame_rx #(
        .MAX_LEN        (MAX_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .receivable (receivable),
        .recv_data  (recv_data),
        .recv_flag  (recv_flag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .frame_err  (frame_err),
        .err_code   (err_code)
    );

    // UART RX FIFO model (first-word fall-through)
    logic [7:0] rx_mem [0:255];
    int         wr_idx = 0;
    int         rd_idx = 0;
    logic       pop_now = 1'b0;
    int         cyc = 0;

    always @(posedge CLK) begin
        pop_now <= recv_flag;
        cyc     <= cyc + 1;
    end

    always @(negedge CLK) begin
        int r;
        r = rd_idx + (pop_now ? 1 : 0);
        rd_idx     <= r;
        receivable <= (r != wr_idx);
        recv_data  <= rx_mem[r[7:0]];
    end

    // Consumer ready: always 1, or a fixed pattern advanced per valid cycle
    bit         ready_mode = 1'b0;
    int         ready_idx = 0;
    logic [5:0] ready_pat = 6'b101001;

    always @(posedge CLK) begin
        #1;
        if (!ready_mode) begin
            out_ready <= 1'b1;
        end else if (out_valid) begin
            out_ready <= ready_pat[ready_idx % 6];
            ready_idx <= ready_idx + 1;
        end else begin
            out_ready <= 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int         checks = 0;
    int         failures = 0;
    logic [8:0] exp_q [$];
    logic [1:0] err_q [$];
    logic [7:0] pl [$];
    int         valid_cycles = 0;
    int         drain_rx_cycles = 0;
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic       prev_err = 1'b0;
    logic [8:0] prev_out = '0;

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step_sync();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        rx_mem[wr_idx[7:0]] = b;
        wr_idx++;
    endtask

    // Frame built from pl; mask != 0 corrupts the checksum byte
    task automatic push_frame(input logic [7:0] mask);
        logic [7:0] c;
        c = 8'(pl.size());
        push_byte(SYNC_BYTE);
        push_byte(8'(pl.size()));
        foreach (pl[i]) begin
            push_byte(pl[i]);
            c ^= pl[i];
        end
        push_byte(c ^ mask);
        if (mask == 8'h00) begin
            foreach (pl[i]) exp_q.push_back({1'(i == pl.size() - 1), pl[i]});
        end else begin
            err_q.push_back(ERR_CSUM);
        end
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int  n;
        bit  done;
        n = 0;
        done = 1'b0;
        while (!done && n < budget) begin
            @(negedge CLK);
            n++;
            done = (rd_idx == wr_idx) && (exp_q.size() == 0) && (err_q.size() == 0)
                   && !out_valid && !pop_now && !receivable;
        end
        @(negedge CLK);
        chk(32'(done), 32'd1, tag);
    endtask

    initial begin
        int v0;
        int d0;
        int t0;
        int n;

        // Output monitor / scoreboard
        fork
            forever begin
                logic [8:0] e;
                logic [1:0] ee;
                @(negedge CLK);
                if (!RST) begin
                    if (out_valid && !prev_valid) chk(32'(pop_now), 32'd1, "first_byte_latency");
                    if (prev_valid && !prev_ready && out_valid)
                        chk(32'({out_last, out_data}), 32'(prev_out), "stall_stable");
                    if (out_valid && receivable) begin
                        chk(32'(recv_flag), 32'd0, "no_pop_in_drain");
                        drain_rx_cycles++;
                    end
                    if (out_valid) valid_cycles++;
                    if (out_valid && out_ready) begin
                        chk(32'(exp_q.size() != 0), 32'd1, "out_expected");
                        if (exp_q.size() != 0) begin
                            e = exp_q.pop_front();
                            chk(32'(out_data), 32'(e[7:0]), "out_data");
                            chk(32'(out_last), 32'(e[8]), "out_last");
                        end
                    end
                    if (frame_err) begin
                        chk(32'(prev_err), 32'd0, "err_one_cycle");
                        chk(32'(err_q.size() != 0), 32'd1, "err_expected");
                        if (err_q.size() != 0) begin
                            ee = err_q.pop_front();
                            chk(32'(err_code), 32'(ee), "err_code");
                        end
                    end
                end
                prev_valid = out_valid;
                prev_ready = out_ready;
                prev_err   = frame_err;
                prev_out   = {out_last, out_data};
            end
        join_none

        // Reset state
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk(32'(out_valid), 32'd0, "rst_out_valid");
        chk(32'(out_last), 32'd0, "rst_out_last");
        chk(32'(out_data), 32'd0, "rst_out_data");
        chk(32'(frame_err), 32'd0, "rst_frame_err");
        chk(32'(err_code), 32'd0, "rst_err_code");
        chk(32'(recv_flag), 32'd0, "rst_recv_flag");
        step_sync();
        RST = 1'b0;

        // Basic frame at full throughput
        step_sync();
        v0 = valid_cycles;
        pl = {8'h11, 8'h22, 8'h33};
        push_frame(8'h00);
        wait_idle(200, "t1_idle");
        chk(32'(valid_cycles - v0), 32'd3, "t1_valid_cycles");

        // Garbage before sync
        step_sync();
        v0 = valid_cycles;
        push_byte(8'h00); push_byte(8'hFF); push_byte(8'h5A);
        pl = {8'h7E};
        push_frame(8'h00);
        wait_idle(200, "t2_idle");
        chk(32'(valid_cycles - v0), 32'd1, "t2_valid_cycles");

        // Bad lengths: zero and above MAX_LEN, with junk after each
        step_sync();
        push_byte(8'hA5); push_byte(8'h00); push_byte(8'h33);
        err_q.push_back(ERR_LEN);
        push_byte(8'hA5); push_byte(8'h11); push_byte(8'h44);
        err_q.push_back(ERR_LEN);
        pl = {8'h5C, 8'hA5};
        push_frame(8'h00);
        wait_idle(200, "t4_idle");
        chk(32'(err_code), 32'(ERR_LEN), "t4_err_held");

        // Bad checksum, then a good frame
        step_sync();
        v0 = valid_cycles;
        pl = {8'h11, 8'h22, 8'h33};
        push_frame(8'h07);
        push_frame(8'h00);
        wait_idle(200, "t3_idle");
        chk(32'(valid_cycles - v0), 32'd3, "t3_valid_cycles");
        chk(32'(err_code), 32'(ERR_CSUM), "t3_err_held");

        // Backpressure with bytes waiting in the FIFO
        step_sync();
        ready_mode = 1'b1;
        v0 = valid_cycles;
        d0 = drain_rx_cycles;
        pl = {8'h11, 8'h22, 8'h33};
        push_frame(8'h00);
        pl = {8'h7E};
        push_frame(8'h00);
        wait_idle(300, "t5_idle");
        chk(32'(valid_cycles - v0), 32'd7, "t5_valid_cycles");
        chk(32'(drain_rx_cycles - d0 >= 6), 32'd1, "t5_drain_with_rx");
        ready_mode = 1'b0;

`ifdef UART_FRAME_TIMEOUT_EN
        // Inter-byte timeout
        step_sync();
        push_byte(8'hA5); push_byte(8'h03); push_byte(8'h11);
        err_q.push_back(ERR_TIMEOUT);
        n = 0;
        while (rd_idx != wr_idx && n < 50) begin
            @(negedge CLK);
            n++;
        end
        t0 = cyc;
        n = 0;
        while (err_q.size() != 0 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        chk(32'(cyc - t0 >= 45 && cyc - t0 <= 55), 32'd1, "t6_timeout_delay");
        chk(32'(err_code), 32'(ERR_TIMEOUT), "t6_err_held");
`else
        t0 = 0;
`endif

        // Reset in the middle of a payload
        step_sync();
        push_byte(8'hA5); push_byte(8'h05); push_byte(8'h01); push_byte(8'h02);
        repeat (8) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        chk(32'(dut.state), 32'(HUNT), "mid_rst_state");
        chk(32'(out_valid), 32'd0, "mid_rst_out_valid");
        chk(32'(out_data), 32'd0, "mid_rst_out_data");
        chk(32'(out_last), 32'd0, "mid_rst_out_last");
        chk(32'(frame_err), 32'd0, "mid_rst_frame_err");
        chk(32'(err_code), 32'd0, "mid_rst_err_code");
        step_sync();
        RST = 1'b0;

        // Recovery after reset
        step_sync();
        v0 = valid_cycles;
        pl = {8'h7E};
        push_frame(8'h00);
        wait_idle(200, "post_rst_idle");
        chk(32'(valid_cycles - v0), 32'd1, "post_rst_valid_cycles");
        chk(32'(exp_q.size()), 32'd0, "exp_q_empty");
        chk(32'(err_q.size()), 32'd0, "err_q_empty");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
